// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and byte-level helpers.
// Imported by the S-box datapaths and the GF(2^8) arithmetic blocks.
package aes_pkg;

   localparam logic [7:0] AES_POLY_RED     = 8'h1B;
   localparam logic [7:0] AES_INV_AFFINE_C = 8'h05;
   localparam logic [7:0] AES_AFFINE_C     = 8'h63;
   localparam logic [7:0] AES_INV_EXP      = 8'hFE;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXP  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [7:0] inv_affine(input logic [7:0] x);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) begin
         b[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8]
              ^ x[(i + 7) % 8] ^ AES_INV_AFFINE_C[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/aes_inv_sbox_seq_gf256_mul.sv
// Combinational GF(2^8) multiplier, modulus x^8+x^4+x^3+x+1.
// Shared by the forward and inverse S-box datapaths.
module gf256_mul
   import aes_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] p
);

   logic [7:0] sh;

   // shift-and-add over the bits of b, reducing a on each doubling
   always_comb begin
      p  = 8'h00;
      sh = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ sh;
         sh = sh[7] ? ({sh[6:0], 1'b0} ^ AES_POLY_RED)
                    : {sh[6:0], 1'b0};
      end
   end

endmodule

// File: rtl/aes_inv_sbox_seq.sv
// Iterative AES inverse S-box: inverse affine, then b^254 by
// square-and-multiply over 8 cycles, valid/ready on both sides.
module aes_inv_sbox_seq
   import aes_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       busy
);

   state_t     state;
   state_t     state_nx;
   logic [7:0] acc;
   logic [7:0] base;
   logic [2:0] cnt;
   logic [7:0] sq;
   logic [7:0] prod;
   logic [7:0] acc_nx;

   gf256_mul u_sq (
      .a (acc),
      .b (acc),
      .p (sq)
   );

   gf256_mul u_mul (
      .a (sq),
      .b (base),
      .p (prod)
   );

   assign acc_nx = AES_INV_EXP[cnt] ? prod : sq;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // next-state and handshake decode, all from registered state
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = EXP;
         end
         EXP: begin
            busy = 1'b1;
            if (cnt == 3'd0) state_nx = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // exponentiation registers and held result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= 8'h01;
         base     <= 8'h00;
         cnt      <= 3'd0;
         out_data <= 8'h00;
      end else if (state == IDLE && in_valid) begin
         base <= inv_affine(in_data);
         acc  <= 8'h01;
         cnt  <= 3'd7;
      end else if (state == EXP) begin
         acc <= acc_nx;
         cnt <= cnt - 3'd1;
         if (cnt == 3'd0) out_data <= acc_nx;
      end
   end

endmodule

// File: doc/aes_inv_sbox_seq.md
# aes_inv_sbox_seq

Iterative AES inverse S-box (InvSubBytes) for one byte per transaction, built from logic rather than a 256-entry table. It applies the inverse affine transform, then computes the GF(2^8) multiplicative inverse as b^254 by square-and-multiply over 8 cycles. It pairs with the forward S-box in the decryption datapath and uses valid/ready handshakes on both sides.

## Interface
- No parameters. All constants come from the shared package.
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input byte is offered
- in_ready  out  1  block can accept; high only in IDLE
- in_data  in  8  ciphertext-side byte, the S-box output to be inverted
- out_valid  out  1  out_data holds a result
- out_ready  in  1  consumer accepts the result
- out_data  out  8  InvSbox(in_data)
- busy  out  1  high in EXP or DONE

## Operation
- States:
  - IDLE: in_ready=1.
  - EXP: 8 iterations.
  - DONE: out_valid=1.
- IDLE → EXP on in_valid && in_ready. At that edge:
  - base ← InvAffine(in_data), where b_i = x_(i+2)%8 ^ x_(i+5)%8 ^ x_(i+7)%8 ^ c_i, c = 8'h05.
  - acc ← 8'h01.
  - cnt ← 3'd7.
- EXP, each cycle:
  - sq = gf_mul(acc, acc).
  - acc ← E[cnt] ? gf_mul(sq, base) : sq, where E = 8'hFE (254).
  - cnt ← cnt − 1.
  - After the cnt==0 iteration: out_data ← new acc and state → DONE.
- DONE: out_data and out_valid hold stable until out_ready. On out_valid && out_ready → IDLE, out_valid ← 0.
- Field arithmetic is GF(2^8) modulo x^8+x^4+x^3+x+1 (reduction constant 8'h1B). All widths are 8 bits, with no carries.
- Zero input to the inversion (in_data = 8'h63 gives base = 0) yields acc = 0 naturally. No special case is needed; the result is 8'h00.
- in_valid asserted while not in IDLE is ignored. in_data is sampled only at the accepting edge; later changes have no effect.
- out_ready asserted outside DONE has no effect.
- Reset (rst_n low, any time, including mid-EXP or DONE): immediate return to IDLE. The in-flight byte is discarded and never produces out_valid.
- Reset values:
  - state = IDLE
  - in_ready = 1 (no transfer is taken while rst_n is low)
  - out_valid = 0
  - out_data = 8'h00
  - busy = 0
  - acc = 8'h01, base = 8'h00, cnt = 3'd0

## Timing
- Accept at edge k. EXP iterations occur at edges k+1 … k+8. out_valid rises after edge k+8, a fixed latency of 8 cycles to out_valid.
- With out_ready held high: the output handshake occurs at edge k+9 and the next accept is possible at edge k+10. Sustained throughput is therefore 1 byte per 10 cycles.
- Backpressure: DONE persists for any number of cycles. There is no overlap; in_ready stays 0 until back in IDLE.
- in_ready, out_valid and busy are decoded from registered state, with no combinational path from in_valid or out_ready.
- Critical path: two chained gf_mul instances (square then multiply) plus a mux, within one cycle.

## Structure
- Package aes_pkg holds:
  - AES_POLY_RED = 8'h1B
  - AES_INV_AFFINE_C = 8'h05
  - AES_AFFINE_C = 8'h63
  - AES_INV_EXP = 8'hFE
  - the state enum typedef (IDLE, EXP, DONE)
  - the inv_affine function
- Sub-module gf256_mul: combinational 8×8 GF(2^8) multiplier. Two instances are used, one for squaring and one for multiplication. The forward datapath reuses the same module.
- Top level contains only the FSM, the acc/base/cnt registers and the output register.

## Test plan
- Single byte, out_ready=1: in_data=8'h63 → out_data=8'h00. Then 8'h7C → 8'h01, 8'h16 → 8'hFF, 8'h00 → 8'h52, 8'hED → 8'h53. out_valid rises exactly 8 cycles after each accept.
- Exhaustive sweep: feed forward_sbox(x) for x = 0…255 → out_data == x for all 256. Check in_ready=0 and busy=1 throughout each transaction.
- Backpressure: out_ready=0 for 20 cycles after the 8'h7C result → out_data stays 8'h01 and out_valid stays 1. in_valid pulses with 8'hAA during this time are not accepted. Release out_ready → handshake, then return to IDLE.
- Input churn: accept 8'h16, then change in_data every cycle during EXP → result is still 8'hFF.
- Reset mid-op: assert rst_n low at EXP cycle 4 → outputs immediately show the reset values. After release, accept 8'h63 → 8'h00 with normal latency and no stale output.
- Back-to-back: in_valid held high with a stream, out_ready=1 → accepts spaced exactly 10 cycles apart, results in order.
